barrel_fetch: RTL

BARREL_FETCH -- requirements
Module: barrel_fetch

---
 rtl/barrel_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/barrel_fetch.sv
// Barrel (fine-grained multithreaded) fetch stage.
// Each hardware thread owns a PC. A round-robin pointer picks the thread that
// fetches this cycle, skipping threads whose enable bit is clear. The fetched
// instruction and its PC are registered into the F/D boundary one cycle later.
module barrel_fetch #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_THREADS   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic [NUM_THREADS-1:0]   thread_en,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f
);

  // addi x0,x0,0 -- inserted whenever the F/D slot carries no real instruction
  localparam logic [DATA_WIDTH-1:0]    NOP     = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);
  localparam logic [BITS_THREADS:0]    NT_W    = (BITS_THREADS+1)'(NUM_THREADS);

  logic [ADDRESS_WIDTH-1:0] pc_all [NUM_THREADS];
  logic [BITS_THREADS-1:0]  cur_tid_q;
  logic [BITS_THREADS-1:0]  cur_tid_d;
  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic                     cur_en;
  logic                     redirect_cur;
  logic                     fetch_go;
  logic                     found;
  logic [BITS_THREADS:0]    cand;

  assign cur_pc       = pc_all[cur_tid_q];
  assign imem_addr    = cur_pc;
  assign cur_en       = thread_en[cur_tid_q];
  // A redirect aimed at the thread currently fetching wins over its increment
  // and turns this slot into a squashed bubble.
  assign redirect_cur = pc_src_e && (tid_e == cur_tid_q);
  assign fetch_go     = !stall_f && cur_en && !redirect_cur;

  // Per-thread PC registers; out-of-range tid_e never matches any thread.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_pc
      localparam logic [BITS_THREADS-1:0] TID = BITS_THREADS'(gi);
      logic [ADDRESS_WIDTH-1:0] pc_q;

      // Redirect first (even while stalled), else step PC on its own fetch slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_q <= RESET_PC;
        end else if (pc_src_e && (tid_e == TID)) begin
          pc_q <= pc_target_e;
        end else if (fetch_go && (cur_tid_q == TID)) begin
          pc_q <= pc_q + PC_STEP;
        end
      end

      assign pc_all[gi] = pc_q;
    end
  endgenerate

  // Next enabled thread in circular order after cur_tid; stays put if none
  always_comb begin
    cur_tid_d = cur_tid_q;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k < NUM_THREADS; k++) begin
      cand = {1'b0, cur_tid_q} + (BITS_THREADS+1)'(k);
      if (cand >= NT_W) begin
        cand = cand - NT_W;
      end
      if (!found && thread_en[cand[BITS_THREADS-1:0]]) begin
        cur_tid_d = cand[BITS_THREADS-1:0];
        found     = 1'b1;
      end
    end
  end

  // Thread pointer advances on every non-stalled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_tid_q <= '0;
    end else if (!stall_f) begin
      cur_tid_q <= cur_tid_d;
    end
  end

  // F/D register: real fetch, squashed slot, or idle bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f       <= '0;
      pc_plus4_f <= '0;
      instr_f    <= NOP;
      tid_f      <= '0;
      valid_f    <= 1'b0;
    end else if (!stall_f) begin
      if (cur_en && !redirect_cur) begin
        pc_f       <= cur_pc;
        pc_plus4_f <= cur_pc + PC_STEP;
        instr_f    <= imem_rdata;
        tid_f      <= cur_tid_q;
        valid_f    <= 1'b1;
      end else if (cur_en) begin
        // squashed slot still reports which thread lost its fetch
        instr_f    <= NOP;
        tid_f      <= cur_tid_q;
        valid_f    <= 1'b0;
      end else begin
        instr_f    <= NOP;
        valid_f    <= 1'b0;
      end
    end
  end

endmodule
